// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that frames one 7-bit word at a time onto a shared serial line.
// Optional frame counter output is enabled by defining SERIAL_ARB_STATS_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, arbitrating among pending requesters
// S_START  | start bit (low) of the granted word
// S_DATA   | seven data bits, LSB first
// S_PARITY | even-parity bit over the data
// S_STOP   | GAP_BITS high stop/gap bit-times, then back to idle

module serial_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int GAP_BITS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [7*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ack,
    output logic                       serial_out,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       tx_done
`ifdef SERIAL_ARB_STATS_EN
    ,
    output logic [15:0]                frame_cnt
`endif
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int IDW1  = ID_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          st, st_nxt;
    logic [6:0]      sh, sh_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [3:0]      gap_cnt, gap_nxt;
    logic            par, par_nxt;
    logic [ID_W-1:0] last, last_nxt;
    logic [ID_W-1:0] gid_nxt;
    logic [N_REQ-1:0] ack_nxt;
    logic            so_nxt;
    logic            busy_nxt;
    logic            done_nxt;

    logic            found;
    logic [ID_W-1:0] win;
    logic [IDW1-1:0] idx;
    logic [6:0]      win_data;
    logic [N_REQ-1:0] win_onehot;

    // Search starts one past the previous winner, so it ends up lowest priority.
    always_comb begin
        found = 1'b0;
        win   = last;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = {1'b0, last} + IDW1'(k);
            if (idx >= IDW1'(N_REQ)) begin
                idx = idx - IDW1'(N_REQ);
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == win) begin
                win_data      = req_data[7*i +: 7];
                win_onehot[i] = found;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        st_nxt   = st;
        sh_nxt   = sh;
        bit_nxt  = bit_cnt;
        gap_nxt  = gap_cnt;
        par_nxt  = par;
        last_nxt = last;
        gid_nxt  = grant_id;
        ack_nxt  = '0;
        so_nxt   = 1'b1;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;

        case (st)
            S_IDLE: begin
                if (found) begin
                    st_nxt   = S_START;
                    sh_nxt   = win_data;
                    par_nxt  = ^win_data;
                    last_nxt = win;
                    gid_nxt  = win;
                    ack_nxt  = win_onehot;
                    so_nxt   = 1'b0;
                    busy_nxt = 1'b1;
                end
            end
            S_START: begin
                st_nxt   = S_DATA;
                bit_nxt  = 3'd0;
                so_nxt   = sh[0];
                busy_nxt = 1'b1;
            end
            S_DATA: begin
                busy_nxt = 1'b1;
                if (bit_cnt == 3'd6) begin
                    st_nxt = S_PARITY;
                    so_nxt = par;
                end else begin
                    bit_nxt = bit_cnt + 3'd1;
                    sh_nxt  = sh >> 1;
                    so_nxt  = sh[1];
                end
            end
            S_PARITY: begin
                st_nxt   = S_STOP;
                gap_nxt  = 4'(GAP_BITS - 1);
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            S_STOP: begin
                if (gap_cnt == 4'd0) begin
                    st_nxt = S_IDLE;
                end else begin
                    gap_nxt  = gap_cnt - 4'd1;
                    busy_nxt = 1'b1;
                end
            end
            default: begin
                st_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            sh         <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            par        <= 1'b0;
            last       <= ID_W'(N_REQ - 1);
            grant_id   <= '0;
            req_ack    <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            st         <= st_nxt;
            sh         <= sh_nxt;
            bit_cnt    <= bit_nxt;
            gap_cnt    <= gap_nxt;
            par        <= par_nxt;
            last       <= last_nxt;
            grant_id   <= gid_nxt;
            req_ack    <= ack_nxt;
            serial_out <= so_nxt;
            busy       <= busy_nxt;
            tx_done    <= done_nxt;
        end
    end

`ifdef SERIAL_ARB_STATS_EN
    // Counts alongside tx_done, so a frame cut short by reset never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (done_nxt) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: tasks queue expected frames, a line monitor
// decodes each frame off serial_out and checks it against the queue head.

module tb_serial_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [7*N-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic           serial_out;
    logic           busy;
    logic [1:0]     grant_id;
    logic           tx_done;
`ifdef SERIAL_ARB_STATS_EN
    logic [15:0]    frame_cnt;
`endif

    serial_tx_arbiter #(.N_REQ(N), .GAP_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .serial_out (serial_out),
        .busy       (busy),
        .grant_id   (grant_id),
        .tx_done    (tx_done)
`ifdef SERIAL_ARB_STATS_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [6:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Requester model: arm[i] words offered, used[i] words acknowledged.
    int   arm[N] = '{default: 0};
    int   used[N] = '{default: 0};
    int   acks_seen = 0;

    bit   mon_en = 1'b1;
    bit   mon_busy = 1'b0;
    bit   spacing_chk = 1'b0;
    int   spacing_epoch = 0;

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ack[i] === 1'b1) begin
                    used[i]++;
                    acks_seen++;
                end
                req_valid[i] = (arm[i] > used[i]);
            end
        end
    end

    // Line monitor: one frame is START, 7 data, parity, stop, one idle cycle.
    initial begin
        exp_t       ent;
        logic [6:0] got;
        logic       pbit;
        bit         stray;
        int         s_cyc;
        int         prev_start;
        prev_start = -1000;
        forever begin
            @(negedge clk);
            if (mon_en && busy === 1'b1 && serial_out === 1'b0) begin
                mon_busy = 1'b1;
                s_cyc = cyc;
                ent.id = -1;
                ent.d = '0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame: frame started at cycle %0d grant_id=%0d with nothing queued", s_cyc, grant_id);
                end else begin
                    ent = exp_q.pop_front();
                end
                total++;
                if (req_ack !== (4'b0001 << ent.id)) begin
                    bad++;
                    $display("FAIL start_ack: req_ack=%b expected one-hot for requester %0d", req_ack, ent.id);
                end
                total++;
                if (int'(grant_id) !== ent.id) begin
                    bad++;
                    $display("FAIL grant_id: got %0d expected %0d", grant_id, ent.id);
                end
                if (spacing_chk && prev_start > spacing_epoch) begin
                    total++;
                    if (s_cyc - prev_start != 11) begin
                        bad++;
                        $display("FAIL start_spacing: got %0d cycles expected 11", s_cyc - prev_start);
                    end
                end
                prev_start = s_cyc;
                stray = 1'b0;
                got = '0;
                for (int b = 0; b < 7; b++) begin
                    @(negedge clk);
                    got[b] = serial_out;
                    if (req_ack !== '0 || tx_done !== 1'b0 || busy !== 1'b1) stray = 1'b1;
                end
                @(negedge clk);
                pbit = serial_out;
                if (req_ack !== '0 || tx_done !== 1'b0 || busy !== 1'b1) stray = 1'b1;
                total++;
                if (got !== ent.d) begin
                    bad++;
                    $display("FAIL data_bits: got %h expected %h", got, ent.d);
                end
                total++;
                if (pbit !== ^ent.d) begin
                    bad++;
                    $display("FAIL parity_bit: got %b expected %b for data %h", pbit, ^ent.d, ent.d);
                end
                total++;
                if (stray) begin
                    bad++;
                    $display("FAIL mid_frame_flags: ack/tx_done/busy wrong during data or parity of requester %0d", ent.id);
                end
                @(negedge clk);
                total++;
                if (serial_out !== 1'b1 || tx_done !== 1'b1 || busy !== 1'b1 || req_ack !== '0) begin
                    bad++;
                    $display("FAIL stop_cycle: serial_out=%b tx_done=%b busy=%b ack=%b expected 1 1 1 0000",
                             serial_out, tx_done, busy, req_ack);
                end
                @(negedge clk);
                total++;
                if (serial_out !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_gap: serial_out=%b tx_done=%b busy=%b expected 1 0 0", serial_out, tx_done, busy);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy || busy === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d frames still queued after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_exp(input int id, input logic [6:0] d);
        exp_t e;
        e.id = id;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (serial_out !== 1'b1) begin bad++; $display("FAIL reset_serial_out: got %b expected 1", serial_out); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++;
        if (req_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b expected 0000", req_ack); end
        total++;
        if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
        total++;
        if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (serial_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: serial_out=%b busy=%b expected 1 0", serial_out, busy);
        end
    endtask

    task automatic test_single();
        int n = 0;
        req_data[20:14] = 7'h55;
        push_exp(2, 7'h55);
        arm[2]++;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        // Word changes after the grant must not reach the line.
        req_data[20:14] = 7'h2A;
        wait_drain(60);
    endtask

    task automatic test_parity();
        logic [6:0] words [3];
        words[0] = 7'h01;
        words[1] = 7'h7F;
        words[2] = 7'h00;
        for (int w = 0; w < 3; w++) begin
            req_data[6:0] = words[w];
            push_exp(0, words[w]);
            arm[0]++;
            wait_drain(60);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_data = {7'h44, 7'h33, 7'h22, 7'h11};
        spacing_epoch = cyc;
        spacing_chk = 1'b1;
        push_exp(0, 7'h11);
        push_exp(1, 7'h22);
        push_exp(2, 7'h33);
        push_exp(3, 7'h44);
        push_exp(0, 7'h11);
        arm[0] += 2;
        arm[1] += 1;
        arm[2] += 1;
        arm[3] += 1;
        wait_drain(120);
        spacing_chk = 1'b0;
    endtask

    task automatic test_fairness();
        int base;
        int n = 0;
        req_data = {7'h13, 7'h00, 7'h2A, 7'h6C};
        push_exp(1, 7'h2A);
        push_exp(3, 7'h13);
        push_exp(1, 7'h2A);
        push_exp(3, 7'h13);
        push_exp(0, 7'h6C);
        push_exp(1, 7'h2A);
        base = acks_seen;
        arm[1] += 3;
        arm[3] += 2;
        while (acks_seen - base < 4 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (acks_seen - base < 4) begin
            bad++;
            $display("FAIL fairness_ack_wait: got %0d acks expected 4", acks_seen - base);
        end
        repeat (3) @(negedge clk);
        arm[0] += 1;
        wait_drain(150);
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        mon_en = 1'b0;
        req_data[13:7] = 7'h5A;
        arm[1]++;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (busy !== 1'b1 || serial_out !== 1'b0 || req_ack !== 4'b0010) begin
            bad++;
            $display("FAIL trunc_start: busy=%b serial_out=%b ack=%b expected 1 0 0010", busy, serial_out, req_ack);
        end
        repeat (4) @(negedge clk);
        total++;
        if (serial_out !== 1'b1) begin
            bad++;
            $display("FAIL trunc_data_bit3: got %b expected 1", serial_out);
        end
        rst = 1'b1;
        req_data[6:0] = 7'h33;
        req_data[20:14] = 7'h4C;
        arm[0]++;
        arm[2]++;
        @(negedge clk);
        total++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || req_ack !== 4'b0000 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_frame: serial_out=%b busy=%b ack=%b tx_done=%b expected 1 0 0000 0",
                     serial_out, busy, req_ack, tx_done);
        end
        total++;
        if (grant_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid_grant_id: got %0d expected 0", grant_id);
        end
        push_exp(0, 7'h33);
        push_exp(2, 7'h4C);
        rst = 1'b0;
        mon_en = 1'b1;
        wait_drain(80);
    endtask

`ifdef SERIAL_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        req_data[6:0] = 7'h19;
        for (int f = 0; f < 3; f++) push_exp(0, 7'h19);
        arm[0] += 3;
        wait_drain(100);
        total++;
        if (frame_cnt !== 16'd3) begin
            bad++;
            $display("FAIL frame_cnt_three: got %0d expected 3", frame_cnt);
        end
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        push_exp(0, 7'h19);
        arm[0] += 1;
        wait_drain(60);
        total++;
        if (frame_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL frame_cnt_wrap: got %h expected 0000", frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_round_robin();
        test_fairness();
        test_reset_mid_frame();
`ifdef SERIAL_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares one serial transmit line among `N_REQ` requesters, each offering 7-bit words. Arbitration is round-robin. The block frames each granted word as start bit, 7 data bits LSB first, even-parity bit and stop/gap bits. It is the transmit-side counterpart of the serial receiver and drives its `serial_in` directly, one bit per clock.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..16.
- `GAP_BITS`, 1: stop/gap bit-times driven high after parity; legal range 1..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i has a word pending; held until its ack.
- `req_data`  in  7*N_REQ  word of requester i at bits [7i+6:7i].
- `req_ack`  out  N_REQ  one-hot, one-cycle pulse; word of requester i has been captured.
- `serial_out`  out  1  serial line; idle high.
- `busy`  out  1  high from START through the last STOP cycle.
- `grant_id`  out  clog2(N_REQ)  index of the requester owning the current frame; holds its last value when idle.
- `tx_done`  out  1  one-cycle pulse in the first STOP cycle of each frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `serial_out`=1, `busy`=0.
  - At a clock edge with any `req_valid` set, select the winner by round-robin.
  - Latch its word into the shift register. Set `grant_id` and `req_ack[winner]`=1. Go to START.
- START, 1 cycle: `serial_out`=0.
- DATA, 7 cycles: `serial_out` = d0, d1, …, d6. A 3-bit counter runs 0..6.
- PARITY, 1 cycle: `serial_out` = XOR of d6..d0. This gives even parity over data+parity.
- STOP, `GAP_BITS` cycles: `serial_out`=1. Then return to IDLE.
- Round-robin:
  - A pointer `last` holds the previous winner.
  - The search order is `last`+1, `last`+2, … modulo N_REQ. The first requester with `req_valid` set wins, and `last` is updated to it.
  - Reset value of `last` is N_REQ-1, so requester 0 has first priority.
- `req_valid`/`req_data` are sampled only at the IDLE→START edge. Changes at any other time are ignored.
- A requester whose valid stays high after its ack is treated as having a new word. It competes again at the next arbitration, behind all other pending requesters.
- Reset mid-frame: at the next edge the FSM goes to IDLE and `serial_out`=1; the frame is truncated, not completed. `last` and all counters are reinitialised.

## Timing
- Reset values:
  - `serial_out`=1, `busy`=0, `req_ack`=0, `tx_done`=0, `grant_id`=0.
  - FSM=IDLE, `last`=N_REQ-1.
- All outputs are registered.
- Edge E0 samples the request. The cycle after E0 is START, with `req_ack`=1 and `busy`=1.
- Cycles E0+2..E0+8 carry data, E0+9 carries parity, and E0+10 is the first STOP cycle, with `tx_done`=1.
- After STOP there is one mandatory IDLE cycle before the next possible START.
- Frame period is 10+GAP_BITS cycles. Line high time between frames is at least GAP_BITS+1 cycles.
- `req_ack` is never asserted for more than one requester or for more than one cycle per frame.

## Configuration
- `SERIAL_ARB_STATS_EN` defined:
  - Adds output port `frame_cnt`, 16 bits, reset 0.
  - It increments by 1 in the cycle `tx_done` is asserted and wraps 0xFFFF→0x0000.
  - Frames truncated by reset are not counted.
- Not defined: the `frame_cnt` port and its counter are absent; all other behaviour is identical.

## Test plan
- Single request: requester 2, data 7'h55, N_REQ=4, GAP_BITS=1.
  - `req_ack`=4'b0100 for exactly one cycle.
  - `serial_out` = 0, 1,0,1,0,1,0,1, 0, 1, 1 (start, data, parity, stop, idle).
  - `grant_id`=2, and `tx_done` pulses in cycle E0+10.
- Parity: data 7'h01 gives parity bit 1; 7'h7F gives 1; 7'h00 gives 0. In each case the receiver reports `parity_ok_n`=0 and `data_out` equal to the sent word.
- Round-robin: all four `req_valid` held high continuously after reset.
  - Grants come in order 0,1,2,3,0.
  - Successive START edges are exactly 11 cycles apart.
- Fairness: requesters 1 and 3 held high.
  - Grants alternate 1,3,1,3.
  - Requester 0 raised mid-frame after grant 3 is granted next, before 1.
- Reset mid-frame: `rst` asserted during DATA bit 3.
  - The next cycle has `serial_out`=1, `busy`=0, no ack.
  - After release, a pending requester 0 is granted first.
- With `SERIAL_ARB_STATS_EN`: 3 frames give `frame_cnt`=3; preloading to 0xFFFF via force and then sending 1 frame gives 0x0000.
